// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
//   Bus bundle between the CPU datapath and the architectural register file.
//   One write port and two independent read ports.
//
//   Signals:
//     RegWrite       write enable
//     WriteRegister  5-bit write address
//     WriteData      WIDTH-bit write data
//     ReadRegister1  5-bit read port 1 address
//     ReadRegister2  5-bit read port 2 address
//     ReadData1      WIDTH-bit read port 1 data
//     ReadData2      WIDTH-bit read port 2 data
//
//   Modports:
//     master  datapath side; drives addresses and write data, receives reads
//     slave   register file side
// ---------------------------------------------------------------------------
interface regfile_if #(
  parameter int WIDTH = 64
);
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2
  );
endinterface

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//   Architectural register file: 32 registers of WIDTH bits, one synchronous
//   write port and two combinational read ports. Index 31 is the hardwired
//   zero register: it has no storage, always reads 0, and writes to it are
//   dropped.
//
//   Ports:
//     clk    sole clock, all state updates on the rising edge
//     reset  synchronous active-high; clears registers 0..30, wins over a
//            simultaneous write
//     rf     regfile_if.slave bundle (write port + two read ports)
//
//   Configuration macro:
//     REGFILE_BYPASS_EN  when defined, a read port whose address matches an
//                        active write (to any index other than 31) returns
//                        WriteData in the same cycle. When undefined, a
//                        same-cycle read sees the old register value.
// ---------------------------------------------------------------------------
module regfile #(
  parameter int WIDTH = 64,
  parameter int NREG  = 32
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  rf
);

  localparam int ZERO_IDX = NREG - 1;

  // Storage for the writable registers only; index 31 has no flops.
  logic [WIDTH-1:0] regs_q [ZERO_IDX];
  logic [WIDTH-1:0] regs_d [ZERO_IDX];

  // One-hot write enable from the 5:32 decoder, gated by RegWrite.
  logic [NREG-1:0]  wr_en;

  // Bit-sliced view: col[b][i] is bit b of register i (index 31 tied to 0).
  logic [NREG-1:0]  col [WIDTH];

  logic [WIDTH-1:0] rd1_mux;
  logic [WIDTH-1:0] rd2_mux;

  always_comb begin
    wr_en = '0;
    if (rf.RegWrite) begin
      wr_en[rf.WriteRegister] = 1'b1;
    end
    // The zero register has no storage, so its enable goes nowhere.
    wr_en[ZERO_IDX] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < ZERO_IDX; i++) begin
      regs_d[i] = wr_en[i] ? rf.WriteData : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ZERO_IDX; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ZERO_IDX; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Per-bit 32:1 multiplexers, one pair per data bit.
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      for (int i = 0; i < ZERO_IDX; i++) begin
        col[b][i] = regs_q[i][b];
      end
      col[b][ZERO_IDX] = 1'b0;
    end
  end

  always_comb begin
    rd1_mux = '0;
    rd2_mux = '0;
    for (int b = 0; b < WIDTH; b++) begin
      rd1_mux[b] = col[b][rf.ReadRegister1];
      rd2_mux[b] = col[b][rf.ReadRegister2];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write so writeback and decode can share a cycle.
  // Index 31 is excluded so the zero register never sees write data.
  logic wr_live;
  logic byp1;
  logic byp2;

  always_comb begin
    wr_live = rf.RegWrite && (rf.WriteRegister != 5'(ZERO_IDX));
    byp1    = wr_live && (rf.ReadRegister1 == rf.WriteRegister);
    byp2    = wr_live && (rf.ReadRegister2 == rf.WriteRegister);
  end

  assign rf.ReadData1 = byp1 ? rf.WriteData : rd1_mux;
  assign rf.ReadData2 = byp2 ? rf.WriteData : rd2_mux;
`else
  assign rf.ReadData1 = rd1_mux;
  assign rf.ReadData2 = rd2_mux;
`endif

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  localparam int W = 64;

  logic clk;
  logic reset;

  regfile_if #(.WIDTH(W)) rif ();

  regfile #(.WIDTH(W), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of architectural register values.
  logic [W-1:0] mem [32];

  int n_checks;
  int n_fails;

  function automatic logic [W-1:0] exp_read(input logic [4:0] a);
    if (a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rif.RegWrite && rif.WriteRegister != 5'd31 && rif.WriteRegister == a)
      return rif.WriteData;
`endif
    return mem[a];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge: update the model from the currently driven inputs,
  // then step past the edge so outputs are sampled away from it.
  task automatic do_edge();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
    end else if (rif.RegWrite && rif.WriteRegister != 5'd31) begin
      mem[rif.WriteRegister] = rif.WriteData;
    end
    #1;
  endtask

  // Reads every address on both ports; write port idle so passing edges
  // leave state untouched.
  task automatic sweep(input string tag);
    rif.RegWrite = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rif.ReadRegister1 = 5'(a);
      rif.ReadRegister2 = 5'(31 - a);
      #1;
      check($sformatf("%s_p1_r%0d", tag, a), rif.ReadData1, exp_read(5'(a)));
      check($sformatf("%s_p2_r%0d", tag, 31 - a), rif.ReadData2, exp_read(5'(31 - a)));
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [W-1:0] d);
    rif.RegWrite      = 1'b1;
    rif.WriteRegister = a;
    rif.WriteData     = d;
    do_edge();
    rif.RegWrite      = 1'b0;
  endtask

  task automatic read1(input logic [4:0] a);
    rif.ReadRegister1 = a;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    reset             = 1'b1;
    rif.RegWrite      = 1'b0;
    rif.WriteRegister = '0;
    rif.WriteData     = '0;
    rif.ReadRegister1 = '0;
    rif.ReadRegister2 = '0;

    // Initial reset
    do_edge();
    reset = 1'b0;
    sweep("post_reset");

    // Reset clear
    write_reg(5'd5, 64'hDEAD_BEEF_0000_0001);
    read1(5'd5);
    check("x5_preload", rif.ReadData1, 64'hDEAD_BEEF_0000_0001);
    reset = 1'b1;
    do_edge();
    reset = 1'b0;
    read1(5'd5);
    check("x5_after_reset", rif.ReadData1, 64'h0);
    sweep("reset_clear");

    // Write/read all
    for (int i = 0; i < 31; i++) begin
      write_reg(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
    end
    sweep("write_all");
    read1(5'd30);
    check("x30_const", rif.ReadData1, 64'h1E1E_1E1E_1E1E_1E1E);

    // Zero register
    rif.RegWrite      = 1'b1;
    rif.WriteRegister = 5'd31;
    rif.WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    rif.ReadRegister1 = 5'd31;
    #1;
    check("x31_during_write", rif.ReadData1, 64'h0);
    do_edge();
    rif.RegWrite = 1'b0;
    read1(5'd31);
    check("x31_after_write", rif.ReadData1, 64'h0);
    sweep("zero_reg");

    // Write enable low
    rif.RegWrite      = 1'b0;
    rif.WriteRegister = 5'd3;
    rif.WriteData     = 64'h1234;
    do_edge();
    read1(5'd3);
    check("x3_we_low", rif.ReadData1, 64'h0303_0303_0303_0303);

    // Reset beats simultaneous write
    rif.RegWrite      = 1'b1;
    rif.WriteRegister = 5'd3;
    rif.WriteData     = 64'h1234;
    reset             = 1'b1;
    do_edge();
    reset        = 1'b0;
    rif.RegWrite = 1'b0;
    read1(5'd3);
    check("x3_reset_priority", rif.ReadData1, 64'h0);

    // Dual-port same address
    write_reg(5'd7, 64'hA5A5);
    rif.ReadRegister1 = 5'd7;
    rif.ReadRegister2 = 5'd7;
    #1;
    check("dual_p1_x7", rif.ReadData1, 64'hA5A5);
    check("dual_p2_x7", rif.ReadData2, 64'hA5A5);

    // Same-cycle hazard
    write_reg(5'd9, 64'h1111);
    rif.RegWrite      = 1'b1;
    rif.WriteRegister = 5'd9;
    rif.WriteData     = 64'h2222;
    rif.ReadRegister1 = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_pre_edge", rif.ReadData1, 64'h2222);
`else
    check("hazard_pre_edge", rif.ReadData1, 64'h1111);
`endif
    do_edge();
    rif.RegWrite = 1'b0;
    #1;
    check("hazard_post_edge", rif.ReadData1, 64'h2222);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      rif.RegWrite      = ($urandom_range(0, 3) != 0);
      rif.WriteRegister = 5'($urandom_range(0, 31));
      rif.WriteData     = {$urandom, $urandom};
      rif.ReadRegister1 = ($urandom_range(0, 3) == 0) ? rif.WriteRegister : 5'($urandom_range(0, 31));
      rif.ReadRegister2 = ($urandom_range(0, 3) == 0) ? rif.WriteRegister : 5'($urandom_range(0, 31));
      reset             = ($urandom_range(0, 49) == 0);
      #1;
      check($sformatf("rnd%0d_pre_p1", it), rif.ReadData1, exp_read(rif.ReadRegister1));
      check($sformatf("rnd%0d_pre_p2", it), rif.ReadData2, exp_read(rif.ReadRegister2));
      do_edge();
      reset        = 1'b0;
      rif.RegWrite = 1'b0;
      #1;
      check($sformatf("rnd%0d_post_p1", it), rif.ReadData1, exp_read(rif.ReadRegister1));
      check($sformatf("rnd%0d_post_p2", it), rif.ReadData2, exp_read(rif.ReadRegister2));
    end

    sweep("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
